mcycle_gen: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the processor datapath. It is the successor of the fixed 32-bit MCycle unit. It adds operand width as a parameter, signed and unsigned variants of both operations, a full double-width product, a remainder output, a Done pulse and divide-by-zero detection. The datapath drives Start from the control unit and stalls the PC while Busy is high. Writeback uses Result1/Result2 when Done is high.

---
 rtl/mcycle_gen.sv | 185 ++++++++++++++++++
 tb/tb_mcycle_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_gen.sv
// mcycle_gen: parametrised multi-cycle multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Ports:
//   CLK, RESET        rising-edge clock, asynchronous active-high reset
//   Start, MCycleOp   request and opcode (00 mulu, 01 muls, 10 divu, 11 divs)
//   Operand1/2        multiplicand/dividend, multiplier/divisor (sampled with Start)
//   Result1/2         product low/high or quotient/remainder
//   Busy              pipeline stall request
//   Done              one-cycle pulse when results are valid
//   DivByZero         last completed divide had a zero divisor
module mcycle_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e state_q, state_d;

  logic               is_div_q, is_div_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic               neg_lo_q, neg_lo_d;   // product / quotient sign
  logic               neg_hi_q, neg_hi_d;   // remainder sign
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;         // {hi, lo}: product or {remainder, quotient}
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               start_dbz;
  logic               s1, s2;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept    = (state_q == StIdle) && Start;
  assign start_dbz = MCycleOp[1] && (Operand2 == '0);
  assign s1        = MCycleOp[0] & Operand1[WIDTH-1];
  assign s2        = MCycleOp[0] & Operand2[WIDTH-1];
  assign op1_abs   = s1 ? -Operand1 : Operand1;
  assign op2_abs   = s2 ? -Operand2 : Operand2;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  // Multiply step: conditionally add multiplicand to the high half, then shift right.
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_q : {WIDTH{1'b0}})};

  // Divide step: shift {rem, quo} left, trial-subtract the divisor from the remainder.
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = start_dbz ? StFin : StRun;
      StRun:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: in idle, Busy follows Start so the PC stalls in the request cycle.
  always_comb begin
    Busy = 1'b0;
    if (!RESET) begin
      Busy = (state_q == StIdle) ? Start : 1'b1;
    end
  end

  // Datapath next-state
  always_comb begin
    is_div_d   = is_div_q;
    dbz_pend_d = dbz_pend_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    res1_d     = res1_q;
    res2_d     = res2_q;
    dbz_d      = dbz_q;
    done_d     = (state_q == StFin);

    if (accept) begin
      is_div_d   = MCycleOp[1];
      dbz_pend_d = start_dbz;
      neg_lo_d   = s1 ^ s2;
      neg_hi_d   = MCycleOp[1] & s1;
      cnt_d      = '0;
      if (MCycleOp[1]) begin
        opnd_d = op2_abs;
        // A zero divisor keeps the raw dividend for the remainder output.
        acc_d  = {{WIDTH{1'b0}}, (start_dbz ? Operand1 : op1_abs)};
      end else begin
        opnd_d = op1_abs;
        acc_d  = {{WIDTH{1'b0}}, op2_abs};
      end
    end else if (state_q == StRun) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_q) begin
        acc_d = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
      end
    end else if (state_q == StFin) begin
      dbz_d = dbz_pend_q;
      if (dbz_pend_q) begin
        res1_d = '1;
        res2_d = acc_lo;
      end else if (is_div_q) begin
        res1_d = neg_lo_q ? -acc_lo : acc_lo;
        res2_d = neg_hi_q ? -acc_hi : acc_hi;
      end else begin
        res1_d = prod_fix[WIDTH-1:0];
        res2_d = prod_fix[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      is_div_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      res1_q     <= '0;
      res2_q     <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      is_div_q   <= is_div_d;
      dbz_pend_q <= dbz_pend_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      res1_q     <= res1_d;
      res2_q     <= res2_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign Result1   = res1_q;
  assign Result2   = res2_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mcycle_gen.sv
module tb_mcycle_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  bit          sel8;

  logic [31:0] r1_32, r2_32;
  logic        busy32, done32, dbz32;
  logic [7:0]  r1_8, r2_8;
  logic        busy8, done8, dbz8;

  logic [31:0] r1_m, r2_m;
  logic        busy_m, done_m, dbz_m;

  int total = 0;
  int bad   = 0;

  logic [63:0] last_r1, last_r2;
  bit          last_dbz;

  always #5 clk = ~clk;

  mcycle_gen #(.WIDTH(32)) u_dut32 (
    .CLK       (clk),
    .RESET     (rst),
    .Start     (start & ~sel8),
    .MCycleOp  (op),
    .Operand1  (opa),
    .Operand2  (opb),
    .Result1   (r1_32),
    .Result2   (r2_32),
    .Busy      (busy32),
    .Done      (done32),
    .DivByZero (dbz32)
  );

  mcycle_gen #(.WIDTH(8)) u_dut8 (
    .CLK       (clk),
    .RESET     (rst),
    .Start     (start & sel8),
    .MCycleOp  (op),
    .Operand1  (opa[7:0]),
    .Operand2  (opb[7:0]),
    .Result1   (r1_8),
    .Result2   (r2_8),
    .Busy      (busy8),
    .Done      (done8),
    .DivByZero (dbz8)
  );

  assign r1_m   = sel8 ? {24'h0, r1_8} : r1_32;
  assign r2_m   = sel8 ? {24'h0, r2_8} : r2_32;
  assign busy_m = sel8 ? busy8 : busy32;
  assign done_m = sel8 ? done8 : done32;
  assign dbz_m  = sel8 ? dbz8 : dbz32;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the sign-interpreted operands.
  function automatic void model(input bit w8, input logic [1:0] mop,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] r1, output logic [63:0] r2,
                                output bit dbz);
    int          w;
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb;
    w    = w8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    dbz  = 1'b0;
    if (!mop[1]) begin
      if (mop[0]) p = sa * sb;
      else        p = ua * ub;
      r1 = p & mask;
      r2 = (p >> w) & mask;
    end else if (ub == 64'd0) begin
      r1  = mask;
      r2  = ua;
      dbz = 1'b1;
    end else if (mop[0]) begin
      p  = sa / sb;
      r1 = p & mask;
      p  = sa % sb;
      r2 = p & mask;
    end else begin
      r1 = ua / ub;
      r2 = ua % ub;
    end
  endfunction

  // Called at a negedge with the unit idle (or in its Done cycle); returns at the
  // negedge of the Done cycle.
  task automatic run_op(input bit w8, input logic [1:0] mop, input logic [31:0] a,
                        input logic [31:0] b, input bit scramble);
    int          n;
    int          exp_n;
    logic [63:0] e1, e2;
    bit          ez;
    sel8  = w8;
    op    = mop;
    opa   = a;
    opb   = b;
    start = 1'b1;
    #1;
    n = 0;
    while (busy_m && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (scramble) begin
        opa = $urandom;
        opb = $urandom;
        op  = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    model(w8, mop, a, b, e1, e2, ez);
    exp_n = ez ? 2 : (w8 ? 10 : 34);
    check_eq("busy_cycles", 64'(n), 64'(exp_n));
    check_eq("done",        {63'h0, done_m}, 64'd1);
    check_eq("result1",     {32'h0, r1_m}, e1);
    check_eq("result2",     {32'h0, r2_m}, e2);
    check_eq("divbyzero",   {63'h0, dbz_m}, {63'h0, ez});
    last_r1  = e1;
    last_r2  = e2;
    last_dbz = ez;
  endtask

  // One idle cycle after Done: pulse gone, results held.
  task automatic idle_check();
    start = 1'b0;
    @(negedge clk);
    check_eq("done_pulse_end", {63'h0, done_m}, 64'd0);
    check_eq("idle_busy",      {63'h0, busy_m}, 64'd0);
    check_eq("hold_r1",        {32'h0, r1_m}, last_r1);
    check_eq("hold_r2",        {32'h0, r2_m}, last_r2);
    check_eq("hold_dbz",       {63'h0, dbz_m}, {63'h0, last_dbz});
  endtask

  function automatic logic [31:0] pick(input bit w8);
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return w8 ? 32'h80 : 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_seen;
    rst   = 1'b1;
    start = 1'b0;
    sel8  = 1'b0;
    op    = 2'b00;
    opa   = '0;
    opb   = '0;
    #2;
    check_eq("rst_busy", {63'h0, busy32}, 64'd0);
    check_eq("rst_r1",   {32'h0, r1_32}, 64'd0);
    check_eq("rst_r2",   {32'h0, r2_32}, 64'd0);
    check_eq("rst_done", {63'h0, done32}, 64'd0);
    check_eq("rst_dbz",  {63'h0, dbz32}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("mulu_lo", {32'h0, r1_m}, 64'h1);
    check_eq("mulu_hi", {32'h0, r2_m}, 64'hFFFF_FFFE);
    idle_check();
    run_op(1'b0, 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check_eq("muls_lo", {32'h0, r1_m}, 64'hFFFF_FFEB);
    check_eq("muls_hi", {32'h0, r2_m}, 64'hFFFF_FFFF);
    run_op(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check_eq("muls_mn_hi", {32'h0, r2_m}, 64'h4000_0000);
    idle_check();
    run_op(1'b0, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("divs_q", {32'h0, r1_m}, 64'hFFFF_FFFD);
    check_eq("divs_r", {32'h0, r2_m}, 64'hFFFF_FFFF);
    run_op(1'b0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);  // back-to-back
    check_eq("divs_ovf_q", {32'h0, r1_m}, 64'h8000_0000);
    idle_check();
    run_op(1'b0, 2'b10, 32'd100, 32'd0, 1'b0);
    check_eq("dbz_r2", {32'h0, r2_m}, 64'd100);
    run_op(1'b0, 2'b10, 32'd10, 32'd3, 1'b0);
    check_eq("div_after_dbz", {63'h0, dbz_m}, 64'd0);
    idle_check();
    run_op(1'b1, 2'b10, 32'd200, 32'd7, 1'b1);
    check_eq("div8_q", {32'h0, r1_m}, 64'd28);
    check_eq("div8_r", {32'h0, r2_m}, 64'd4);
    idle_check();

    // Reset mid-multiply, Start held high through reset
    sel8  = 1'b0;
    op    = 2'b00;
    opa   = 32'h1234_5678;
    opb   = 32'h9ABC_DEF0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check_eq("abort_busy", {63'h0, busy32}, 64'd0);
    check_eq("abort_r1",   {32'h0, r1_32}, 64'd0);
    check_eq("abort_r2",   {32'h0, r2_32}, 64'd0);
    check_eq("abort_done", {63'h0, done32}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_start_busy", {63'h0, busy32}, 64'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    run_op(1'b0, 2'b01, 32'hFFFF_FFF0, 32'h0000_1234, 1'b0);
    idle_check();

    // Randomized mix of widths, ops, back-to-back and idle gaps
    for (int i = 0; i < 60; i++) begin
      bit w8;
      w8 = 1'($urandom_range(0, 1));
      if (w8 != sel8) idle_check();
      run_op(w8, 2'($urandom_range(0, 3)), pick(w8), pick(w8), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
